aes_display_sequencer: RTL and testbench

Producer side of the 16-bit display latch interface. Accepts one 128-bit AES state/result block through a valid/ready handshake and presents it to the display path as eight 16-bit words. Each word is driven on o_data together with a one-cycle o_refresh_display pulse. Words advance on a dwell timer or on a user "next" request. Sits between the AES core output and the display latch.

---
 rtl/aes_display_pkg.sv | 21 ++
 rtl/rise_detect.sv | 30 +++
 rtl/aes_display_sequencer.sv | 111 +++++++++++
 tb/tb_aes_display_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_display_pkg.sv
// rtl/aes_display_pkg.sv - shared types, sizes and word slicing for the AES display sequencer
package aes_display_pkg;

    localparam int WORD_W          = 16;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int BLOCK_W         = 128;
    localparam int IDX_W           = 3;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DWELL
    } seq_state_t;

    // Word k of a block; bit 0 of the block is the MSB, so word 0 is bits [0:15].
    function automatic logic [0:WORD_W-1] word_select(input logic [0:BLOCK_W-1] blk,
                                                      input logic [IDX_W-1:0]   k);
        return blk[int'(k) * WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - single-cycle rising-edge detector for a level input
module rise_detect #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic level_q;
    logic level_d;

    // Previous level is just the input delayed by one clock.
    always_comb begin
        level_d = i_level;
    end

    // Resetting to RESET_VAL=1 stops a level held through reset from reading as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= RESET_VAL;
        end else begin
            level_q <= level_d;
        end
    end

    assign o_rise = i_level && !level_q;

endmodule

// File: rtl/aes_display_sequencer.sv
// rtl/aes_display_sequencer.sv - presents one 128-bit AES block as eight 16-bit display words
module aes_display_sequencer
    import aes_display_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter bit AUTO_ADVANCE = 1'b1
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [0:BLOCK_W-1] i_block,
    input  logic               i_block_valid,
    output logic               o_block_ready,
    input  logic               i_next,
    input  logic               i_hold,
    output logic [0:WORD_W-1]  o_data,
    output logic               o_refresh_display,
    output logic [IDX_W-1:0]   o_word_idx,
    output logic               o_busy
);

    localparam int                   TIMER_W    = $clog2(DWELL_CYCLES);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(DWELL_CYCLES - 1);

    seq_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [0:BLOCK_W-1] buf_q, buf_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [0:WORD_W-1]  data_q, data_d;
    logic               refresh_q, refresh_d;
    logic               next_rise;
    logic               timer_expired;
    logic               advance;

    rise_detect #(
        .RESET_VAL (1'b1)
    ) u_next_rise (
        .clk     (clk),
        .rst_n   (i_rst_n),
        .i_level (i_next),
        .o_rise  (next_rise)
    );

    // The pulse cycle is not part of the dwell count, giving DWELL_CYCLES+2 between pulses.
    assign timer_expired = AUTO_ADVANCE && !i_hold && !refresh_q && (timer_q == TIMER_LAST);
    assign advance       = timer_expired || next_rise;

    // Next-state, buffer, index, timer and display-word computation.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        timer_d   = timer_q;
        data_d    = data_q;
        refresh_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_block_valid) begin
                    buf_d   = i_block;
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                data_d    = word_select(buf_q, idx_q);
                refresh_d = 1'b1;
                timer_d   = '0;
                state_d   = DWELL;
            end
            DWELL: begin
                if (advance) begin
                    if (idx_q == IDX_W'(WORDS_PER_BLOCK - 1)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = EMIT;
                    end
                end else if (!i_hold && !refresh_q && timer_q != TIMER_LAST) begin
                    // Saturates so manual mode cannot wrap the counter.
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any block in flight.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            buf_q     <= '0;
            timer_q   <= '0;
            data_q    <= '0;
            refresh_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            timer_q   <= timer_d;
            data_q    <= data_d;
            refresh_q <= refresh_d;
        end
    end

    assign o_block_ready     = (state_q == IDLE);
    assign o_busy            = (state_q != IDLE);
    assign o_data            = data_q;
    assign o_refresh_display = refresh_q;
    assign o_word_idx        = idx_q;

endmodule

// File: tb/tb_aes_display_sequencer.sv
// tb/tb_aes_display_sequencer.sv - directed self-checking bench for aes_display_sequencer
module tb_aes_display_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;

    logic [0:127] a_block, b_block;
    logic         a_valid, b_valid;
    logic         a_ready, b_ready;
    logic         a_next, b_next;
    logic         a_hold, b_hold;
    logic [0:15]  a_data, b_data;
    logic         a_refresh, b_refresh;
    logic [2:0]   a_idx, b_idx;
    logic         a_busy, b_busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [127:0] blk1 = 128'h00112233445566778899AABBCCDDEEFF;
    logic [127:0] blk2 = 128'h0123456789ABCDEF0123456789ABCDEF;
    logic [127:0] blk3 = 128'hFFFF1111222233334444555566660000;
    logic [15:0]  exp_words [8] = '{16'h0011, 16'h2233, 16'h4455, 16'h6677,
                                    16'h8899, 16'hAABB, 16'hCCDD, 16'hEEFF};

    always #5 clk = ~clk;

    aes_display_sequencer #(.DWELL_CYCLES(4), .AUTO_ADVANCE(1'b1)) u_dut_auto (
        .clk               (clk),
        .i_rst_n           (rst_n),
        .i_block           (a_block),
        .i_block_valid     (a_valid),
        .o_block_ready     (a_ready),
        .i_next            (a_next),
        .i_hold            (a_hold),
        .o_data            (a_data),
        .o_refresh_display (a_refresh),
        .o_word_idx        (a_idx),
        .o_busy            (a_busy)
    );

    aes_display_sequencer #(.DWELL_CYCLES(4), .AUTO_ADVANCE(1'b0)) u_dut_man (
        .clk               (clk),
        .i_rst_n           (rst_n),
        .i_block           (b_block),
        .i_block_valid     (b_valid),
        .o_block_ready     (b_ready),
        .i_next            (b_next),
        .i_hold            (b_hold),
        .o_data            (b_data),
        .o_refresh_display (b_refresh),
        .o_word_idx        (b_idx),
        .o_busy            (b_busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_a(input logic [127:0] blk);
        @(negedge clk);
        check("a_ready_before_send", a_ready, 1'b1);
        a_block = blk;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    // Counts negedges until a pulse is seen (bounded), starting from 'start' cycles already elapsed.
    task automatic wait_pulse_a(input string tag, input int start, output int n);
        n = start;
        do begin
            @(negedge clk);
            n++;
        end while (!a_refresh && n < 60);
        check(tag, a_refresh, 1'b1);
    endtask

    int n;
    int pulses;

    initial begin
        rst_n = 1'b0;
        a_block = '0; a_valid = 1'b0; a_next = 1'b0; a_hold = 1'b0;
        b_block = '0; b_valid = 1'b0; b_next = 1'b0; b_hold = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", a_data, 16'h0000);
        check("rst_ready", a_ready, 1'b1);
        check("rst_busy", a_busy, 1'b0);
        rst_n = 1'b1;

        // Auto sequence: first pulse 2 clocks after valid, then 6 apart.
        send_a(blk1);
        n = 1;
        for (int k = 0; k < 8; k++) begin
            wait_pulse_a("auto_pulse", n, n);
            check("auto_spacing", n, (k == 0) ? 2 : 6);
            check("auto_data", a_data, exp_words[k]);
            check("auto_idx", a_idx, k[2:0]);
            @(negedge clk);
            check("auto_single_cycle", a_refresh, 1'b0);
            n = 1;
        end
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_refresh) pulses++;
        end
        check("auto_no_extra_pulse", pulses, 0);
        check("auto_end_ready", a_ready, 1'b1);
        check("auto_end_busy", a_busy, 1'b0);
        check("auto_end_data", a_data, 16'hEEFF);

        // Asynchronous reset mid-cycle takes effect before the next edge.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_data", a_data, 16'h0000);
        check("async_rst_refresh", a_refresh, 1'b0);
        check("async_rst_busy", a_busy, 1'b0);
        check("async_rst_ready", a_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Manual mode: one advance per rising edge of i_next.
        @(negedge clk);
        b_block = blk1;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        @(negedge clk);
        check("man_first_pulse", b_refresh, 1'b1);
        check("man_first_data", b_data, 16'h0011);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (b_refresh) pulses++;
        end
        check("man_no_auto", pulses, 0);
        b_next = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (b_refresh) pulses++;
        end
        b_next = 1'b0;
        check("man_one_pulse", pulses, 1);
        check("man_data", b_data, 16'h2233);
        check("man_idx", b_idx, 3'd1);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (b_refresh) pulses++;
        end
        check("man_quiet", pulses, 0);

        // Hold freezes auto-advance; release resumes within one period.
        send_a(blk1);
        wait_pulse_a("hold_first", 1, n);
        check("hold_first_data", a_data, 16'h0011);
        @(negedge clk);
        a_hold = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_refresh) pulses++;
        end
        check("hold_no_pulse", pulses, 0);
        check("hold_idx", a_idx, 3'd0);
        a_hold = 1'b0;
        wait_pulse_a("hold_release", 0, n);
        check("hold_latency_ok", (n <= 6), 1'b1);
        check("hold_data", a_data, 16'h2233);

        // Timer expiry and next_rise in the same cycle advance once.
        repeat (4) @(negedge clk);
        a_next = 1'b1;
        wait_pulse_a("coll_pulse", 0, n);
        check("coll_spacing", n, 2);
        check("coll_idx", a_idx, 3'd2);
        check("coll_data", a_data, 16'h4455);
        a_next = 1'b0;

        // A different block offered while busy is ignored.
        a_block = blk2;
        a_valid = 1'b1;
        @(negedge clk);
        check("busy_not_ready", a_ready, 1'b0);
        @(negedge clk);
        a_valid = 1'b0;
        n = 2;
        for (int k = 3; k < 8; k++) begin
            wait_pulse_a("busy_pulse", n, n);
            check("busy_data", a_data, exp_words[k]);
            check("busy_idx", a_idx, k[2:0]);
            n = 0;
        end
        repeat (8) @(negedge clk);
        check("busy_end_data", a_data, 16'hEEFF);
        check("busy_end_ready", a_ready, 1'b1);

        // Reset at idx 3 abandons the block; a new block starts from word 0.
        send_a(blk1);
        n = 1;
        for (int k = 0; k < 4; k++) begin
            wait_pulse_a("mid_pulse", n, n);
            n = 0;
        end
        check("mid_idx_before", a_idx, 3'd3);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_idx", a_idx, 3'd0);
        check("mid_rst_busy", a_busy, 1'b0);
        rst_n = 1'b1;
        send_a(blk3);
        wait_pulse_a("mid_new_pulse", 1, n);
        check("mid_new_data", a_data, 16'hFFFF);
        check("mid_new_idx", a_idx, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
